// File: rtl/tfhe_axi_wr_burst_engine.sv
// AXI4 write-burst sequencer: streams PBS results to host memory one burst at a time.
// Optional macro TFHE_WR_ALIGN_CHECK_EN rejects a base address not aligned to one burst.
module tfhe_axi_wr_burst_engine #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_num_bursts,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic                  M_AXI_WLAST,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int unsigned BurstBytesInt = BURST_LEN * DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BurstBytes = ADDR_WIDTH'(BurstBytesInt);
  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] OneBurst = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  misaligned;
  logic                  w_beat;

`ifdef TFHE_WR_ALIGN_CHECK_EN
  assign misaligned = (i_base_addr % BurstBytes) != '0;
`else
  assign misaligned = 1'b0;
`endif

  assign w_beat = s_valid && M_AXI_WREADY;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (i_num_bursts == '0) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            addr_d   = i_base_addr;
            remain_d = i_num_bursts;
            err_d    = 1'b0;
            state_d  = StAw;
          end
        end
      end
      StAw: begin
        if (M_AXI_AWREADY) begin
          beat_d  = '0;
          state_d = StW;
        end
      end
      StW: begin
        if (w_beat) begin
          if (beat_q == LastBeat) begin
            state_d = StB;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StB: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            err_d = 1'b1;
          end
          // Address wraps modulo 2^ADDR_WIDTH by natural overflow.
          if (remain_q > OneBurst) begin
            remain_d = remain_q - OneBurst;
            addr_d   = addr_q + BurstBytes;
            state_d  = StAw;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode from reset state registers, so they are all low while in reset.
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);
  assign o_err         = (state_q == StDone) && err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = (state_q == StAw);
  assign M_AXI_WDATA   = s_data;
  assign M_AXI_WVALID  = (state_q == StW) && s_valid;
  assign s_ready       = (state_q == StW) && M_AXI_WREADY;
  assign M_AXI_WLAST   = (state_q == StW) && (beat_q == LastBeat);
  assign M_AXI_BREADY  = (state_q == StB);

endmodule

// File: tb/tb_tfhe_axi_wr_burst_engine.sv
// Scoreboard bench for tfhe_axi_wr_burst_engine: randomised slave/stream timing, queued expectations.
module tb_tfhe_axi_wr_burst_engine;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 256;
  localparam int unsigned BL = 16;
  localparam int unsigned CW = 16;
  localparam logic [AW-1:0] BB = AW'(BL * DW / 8);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_bursts = '0;
  logic          busy, done, err;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] awaddr;
  logic          awvalid, wvalid, wlast, bready;
  logic          awready = 1'b0;
  logic          wready = 1'b0;
  logic [DW-1:0] wdata;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;

  tfhe_axi_wr_burst_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_num_bursts (num_bursts),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_WLAST  (wlast),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [AW-1:0] exp_aw[$];
  beat_t         exp_w[$];
  logic          exp_done[$];
  logic [DW-1:0] src_q[$];
  logic [1:0]    bresp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;
  int            b_pending = 0;
  int            last_bhs = 0;
  int            start_cyc = 0;
  int            lat_mode = 0;
  bit            bp = 1'b0;
  bit            s_took = 1'b0;
  bit            b_took = 1'b0;
  bit            aw_wait = 1'b0;
  logic [AW-1:0] aw_hold = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Slave and stream source: outputs change only just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        awready = 1'b0;
        wready  = 1'b0;
        s_valid = 1'b0;
        bvalid  = 1'b0;
      end else begin
        awready = bp ? ($urandom % 3 != 0) : 1'b1;
        wready  = bp ? ($urandom % 3 != 0) : 1'b1;
        if (!s_valid || s_took) begin
          s_valid = (src_q.size() > 0) && (!bp || ($urandom % 4 != 0));
          s_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
        if (!bvalid || b_took) begin
          bvalid = (b_pending > 0) && (!bp || ($urandom % 2 == 0));
          bresp  = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops and compares on every handshake.
  always @(negedge clk) begin
    s_took = 1'b0;
    b_took = 1'b0;
    if (rst) begin
      exp_aw.delete();
      exp_w.delete();
      exp_done.delete();
      src_q.delete();
      bresp_q.delete();
      b_pending = 0;
      aw_wait   = 1'b0;
      lat_mode  = 0;
    end else begin
      if (awvalid) begin
        checks++;
        if (wvalid) begin
          errors++;
          $display("FAIL aw_w_overlap: got awvalid=1 wvalid=1 expected wvalid=0");
        end
        if (aw_wait) chk("awaddr_stable", awaddr, aw_hold);
        if (awready) begin
          if (exp_aw.size() == 0) fail_now("unexpected_aw", 1, 0);
          else chk("awaddr", awaddr, exp_aw.pop_front());
          aw_wait = 1'b0;
        end else begin
          aw_wait = 1'b1;
          aw_hold = awaddr;
        end
      end else if (aw_wait) begin
        fail_now("awvalid_dropped", 0, 1);
        aw_wait = 1'b0;
      end
      if (wvalid && wready) begin
        beat_t e;
        s_took = 1'b1;
        chk("s_ready", s_ready, 1);
        if (src_q.size() > 0) void'(src_q.pop_front());
        if (exp_w.size() == 0) fail_now("unexpected_w", 1, 0);
        else begin
          e = exp_w.pop_front();
          chk("wdata", wdata, e.data);
          chk("wlast", wlast, e.last);
          if (wlast) b_pending++;
        end
      end
      if (bvalid && bready) begin
        b_took = 1'b1;
        if (b_pending > 0) b_pending--;
        if (bresp_q.size() > 0) void'(bresp_q.pop_front());
        last_bhs = cyc;
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) fail_now("unexpected_done", 1, 0);
        else chk("done_err", err, exp_done.pop_front());
        if (lat_mode == 1) chk("done_after_b", cyc, last_bhs + 1);
        if (lat_mode == 2) begin
          checks++;
          if (cyc - start_cyc > 2) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles expected <= 2", cyc - start_cyc);
          end
        end
        lat_mode = 0;
      end
    end
  end

  // Reference model: expected traffic derived from base, count and the chosen responses.
  task automatic push_cmd(input logic [AW-1:0] base, input int num, input int err_mode);
    bit misal;
    bit e_any;
    logic [1:0] r;
    logic [DW-1:0] d;
`ifdef TFHE_WR_ALIGN_CHECK_EN
    misal = (base % BB) != 0;
`else
    misal = 1'b0;
`endif
    if (misal || num == 0) begin
      exp_done.push_back(misal);
      lat_mode = 2;
    end else begin
      e_any = 1'b0;
      for (int k = 0; k < num; k++) begin
        exp_aw.push_back(base + AW'(k) * BB);
        if (err_mode == 1) r = (k == 0) ? 2'b10 : 2'b00;
        else if (err_mode == 2) r = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        else r = 2'b00;
        bresp_q.push_back(r);
        e_any |= (r != 2'b00);
        for (int j = 0; j < int'(BL); j++) begin
          for (int i = 0; i < int'(DW / 32); i++) d[i*32+:32] = $urandom;
          src_q.push_back(d);
          exp_w.push_back('{data: d, last: (j == int'(BL) - 1)});
        end
      end
      exp_done.push_back(e_any);
      lat_mode = 1;
    end
    start      = 1'b1;
    base_addr  = base;
    num_bursts = CW'(num);
    start_cyc  = cyc;
    @(posedge clk);
    #2;
    start      = 1'b0;
    base_addr  = {$urandom, $urandom};
    num_bursts = CW'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) begin
      fail_now("done_timeout", done_cnt, target);
      do_reset();
    end else begin
      checks++;
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] base, input int num, input int err_mode,
                         input bit poke);
    int target;
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    target = done_cnt + 1;
    push_cmd(base, num, err_mode);
    if (poke) begin
      repeat (2) @(posedge clk);
      #2;
      start      = 1'b1;
      num_bursts = CW'(7);
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    wait_done(target);
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_wlast"}, wlast, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  initial begin
    int n;
    int target;
    logic [AW-1:0] b;
    repeat (3) @(posedge clk);
    #2;
    check_all_low("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #2;
    check_all_low("after_reset");

    run_cmd(64'h1000, 1, 0, 1'b0);
    run_cmd(64'h2000, 3, 0, 1'b0);
    run_cmd(64'h3000, 2, 1, 1'b0);
    run_cmd(64'h4000, 0, 0, 1'b0);
    run_cmd(64'h5000, 2, 0, 1'b1);
    run_cmd(64'hFFFF_FFFF_FFFF_FE00, 2, 0, 1'b0);
    run_cmd(64'h1010, 1, 0, 1'b0);

    bp = 1'b1;
    for (int t = 0; t < 12; t++) begin
      b = {$urandom, $urandom} & ~(BB - 1);
      run_cmd(b, (t % 5 == 4) ? 0 : int'($urandom_range(1, 4)), 2, 1'b0);
    end

    // Reset in the middle of a data phase.
    bp = 1'b0;
    @(posedge clk);
    #2;
    target = done_cnt;
    push_cmd(64'h8000, 2, 0);
    n = 0;
    while (exp_w.size() > 2 * int'(BL) - 5 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_low("mid_w_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("mid_w_no_done", done_cnt, target);

    run_cmd(64'h9000, 1, 0, 1'b0);

    target = done_cnt;
    repeat (20) @(posedge clk);
    chk("idle_no_done", done_cnt, target);
    chk("aw_queue_empty", exp_aw.size(), 0);
    chk("w_queue_empty", exp_w.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
